// File: rtl/spi_mem_responder_if.sv
// Bus bundle between an SPI master (bench or memory-bus bridge) and the
// spi_mem_responder device model.
//   sclk, cs_n, mosi          : master -> responder SPI pins (mode 0)
//   miso, miso_oe             : responder data out and its drive enable
//   busy                      : responder selected (synchronised cs_n)
//   wr_strobe/wr_addr/wr_data : committed-write side channel
interface spi_mem_responder_if #(
  parameter int unsigned DEPTH_LOG2 = 6
) ();
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic                  busy;
  logic                  wr_strobe;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [7:0]            wr_data;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe, busy, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe, busy, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder emulating a small byte-addressed serial RAM.
// Decodes READ (0x03) / WRITE (0x02), takes a 24-bit address (low DEPTH_LOG2
// bits kept), then streams data bytes MSB first with address auto-increment.
// Ports:
//   clk   : system clock, SPI pins are oversampled on it
//   rst_n : asynchronous active-low reset (clears storage too)
//   bus   : spi_mem_responder_if slave modport (SPI pins + write side channel)
module spi_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned ADDR_BYTES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_mem_responder_if.slave    bus
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned ADDR_BITS = ADDR_BYTES * 8;
  localparam int unsigned CNT_W     = $clog2(ADDR_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_RD,
    ST_ADDR_WR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_IGNORE
  } state_t;

  // Synchronisers; chip select is carried inverted so it resets to "deselected"
  logic [1:0] r_sclk_s;
  logic [1:0] r_sel_s;
  logic [1:0] r_mosi_s;
  logic       r_sclk_q;
  logic       r_sel_q;

  state_t                r_state, w_state_n;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_n;
  logic [6:0]            r_shift, w_shift_n;
  logic [DEPTH_LOG2-1:0] r_addr, w_addr_n;
  logic [7:0]            r_tx, w_tx_n;
  logic                  r_miso, w_miso_n;
  logic                  r_miso_oe, w_miso_oe_n;
  logic                  r_wr_strobe, w_wr_strobe_n;
  logic [DEPTH_LOG2-1:0] r_wr_addr, w_wr_addr_n;
  logic [7:0]            r_wr_data, w_wr_data_n;
  logic                  w_mem_we;
  logic [7:0]            r_mem [DEPTH];

  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_sel;
  logic       w_sel_rise;
  logic       w_mosi;
  logic [7:0] w_rx_byte;
  logic [7:0] w_rd_byte;

  // Pin synchronisers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 2'b00;
      r_sel_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sclk_q <= 1'b0;
      // Assume "already selected" so a cs_n held low through reset does not open a frame
      r_sel_q  <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sclk};
      r_sel_s  <= {r_sel_s[0], ~bus.cs_n};
      r_mosi_s <= {r_mosi_s[0], bus.mosi};
      r_sclk_q <= r_sclk_s[1];
      r_sel_q  <= r_sel_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_q;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_q;
  assign w_sel       = r_sel_s[1];
  assign w_sel_rise  = r_sel_s[1] & ~r_sel_q;
  assign w_mosi      = r_mosi_s[1];
  assign w_rx_byte   = {r_shift, w_mosi};
  assign w_rd_byte   = r_mem[r_addr];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_shift     <= w_shift_n;
      r_addr      <= w_addr_n;
      r_tx        <= w_tx_n;
      r_miso      <= w_miso_n;
      r_miso_oe   <= w_miso_oe_n;
      r_wr_strobe <= w_wr_strobe_n;
      r_wr_addr   <= w_wr_addr_n;
      r_wr_data   <= w_wr_data_n;
    end
  end

  // Storage array, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_mem_we) begin
      r_mem[r_addr] <= w_rx_byte;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_shift_n     = r_shift;
    w_addr_n      = r_addr;
    w_tx_n        = r_tx;
    w_miso_n      = r_miso;
    w_wr_strobe_n = 1'b0;
    w_wr_addr_n   = r_wr_addr;
    w_wr_data_n   = r_wr_data;
    w_mem_we      = 1'b0;

    if (!w_sel) begin
      // Deselect aborts any state; partial bytes are simply dropped
      w_state_n   = ST_IDLE;
      w_bit_cnt_n = '0;
      w_miso_n    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_sel_rise) begin
            w_state_n   = ST_CMD;
            w_bit_cnt_n = '0;
            w_shift_n   = '0;
          end
        end

        ST_CMD: begin
          if (w_sclk_rise) begin
            w_shift_n = w_rx_byte[6:0];
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_n = '0;
              unique case (w_rx_byte)
                8'h03:   w_state_n = ST_ADDR_RD;
                8'h02:   w_state_n = ST_ADDR_WR;
                default: w_state_n = ST_IGNORE;
              endcase
            end else begin
              w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_ADDR_RD, ST_ADDR_WR: begin
          // Shifting through the address register keeps only the low bits
          if (w_sclk_rise) begin
            w_addr_n = {r_addr[DEPTH_LOG2-2:0], w_mosi};
            if (r_bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
              w_bit_cnt_n = '0;
              w_state_n   = (r_state == ST_ADDR_RD) ? ST_DATA_RD : ST_DATA_WR;
            end else begin
              w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_DATA_RD: begin
          // A falling edge at bit 0 starts a new byte: load storage and drive its MSB
          if (w_sclk_fall) begin
            if (r_bit_cnt == '0) begin
              w_miso_n = w_rd_byte[7];
              w_tx_n   = {w_rd_byte[6:0], 1'b0};
            end else begin
              w_miso_n = r_tx[7];
              w_tx_n   = {r_tx[6:0], 1'b0};
            end
          end
          if (w_sclk_rise) begin
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_n = '0;
              w_addr_n    = r_addr + DEPTH_LOG2'(1);
            end else begin
              w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_DATA_WR: begin
          if (w_sclk_rise) begin
            w_shift_n = w_rx_byte[6:0];
            if (r_bit_cnt == CNT_W'(7)) begin
              w_bit_cnt_n   = '0;
              w_mem_we      = 1'b1;
              w_wr_strobe_n = 1'b1;
              w_wr_addr_n   = r_addr;
              w_wr_data_n   = w_rx_byte;
              w_addr_n      = r_addr + DEPTH_LOG2'(1);
            end else begin
              w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_IGNORE: begin
          w_state_n = ST_IGNORE;
        end

        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end

    w_miso_oe_n = (w_state_n == ST_DATA_RD);
  end

  assign bus.miso      = r_miso;
  assign bus.miso_oe   = r_miso_oe;
  assign bus.busy      = r_sel_s[1];
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench for spi_mem_responder: directed SPI frames, expected
// read bytes and write commits queued by the stimulus, compared by a monitor.
module tb_spi_mem_responder;

  localparam int HALF = 6;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;
  int oe_cycles = 0;

  logic [7:0] exp_rd [$];
  wr_t        exp_wr [$];

  spi_mem_responder_if #(.DEPTH_LOG2(6)) bus_if ();

  spi_mem_responder #(.DEPTH_LOG2(6), .ADDR_BYTES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    bus_if.mosi = b;
    tick(HALF);
    bus_if.sclk = 1'b1;
    tick(HALF);
    bus_if.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sclk_bit(b[i]);
  endtask

  task automatic start_frame(input logic [7:0] cmd, input logic [23:0] a);
    bus_if.cs_n = 1'b0;
    tick(HALF);
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic end_frame();
    tick(HALF);
    bus_if.cs_n = 1'b1;
    tick(4 * HALF);
  endtask

  task automatic expect_rd(input logic [7:0] b);
    exp_rd.push_back(b);
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // Monitor: collects miso bytes on sclk rises and write commits, pops and compares
  initial begin
    logic [7:0] mon_sh;
    int         mon_cnt;
    logic       prev_sclk;
    wr_t        w;
    logic [7:0] e;
    mon_sh    = '0;
    mon_cnt   = 0;
    prev_sclk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.miso_oe) oe_cycles++;
      if (bus_if.wr_strobe) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, required no write",
                   bus_if.wr_addr, bus_if.wr_data);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus_if.wr_addr), 32'(w.a));
          check("wr_data", 32'(bus_if.wr_data), 32'(w.d));
        end
      end
      if (!rst_n || bus_if.cs_n) begin
        mon_cnt = 0;
      end else if (bus_if.sclk && !prev_sclk && bus_if.miso_oe) begin
        mon_sh = {mon_sh[6:0], bus_if.miso};
        mon_cnt++;
        if (mon_cnt == 8) begin
          mon_cnt = 0;
          if (exp_rd.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: got byte %0h, required none", mon_sh);
          end else begin
            e = exp_rd.pop_front();
            check("rd_data", 32'(mon_sh), 32'(e));
          end
        end
      end
      prev_sclk = bus_if.sclk;
    end
  end

  initial begin
    int oe_before;
    rst_n       = 1'b0;
    bus_if.cs_n = 1'b1;
    bus_if.sclk = 1'b0;
    bus_if.mosi = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    check("rst_miso_oe",   32'(bus_if.miso_oe),   32'd0);
    check("rst_busy",      32'(bus_if.busy),      32'd0);
    check("rst_miso",      32'(bus_if.miso),      32'd0);
    check("rst_wr_strobe", 32'(bus_if.wr_strobe), 32'd0);
    check("rst_wr_addr",   32'(bus_if.wr_addr),   32'd0);
    check("rst_wr_data",   32'(bus_if.wr_data),   32'd0);

    // Read of fresh storage
    expect_rd(8'h00);
    start_frame(8'h03, 24'h000010);
    check("busy_in_frame", 32'(bus_if.busy), 32'd1);
    send_byte(8'h00);
    end_frame();

    // Write burst, then read back with one untouched byte
    expect_wr(6'd4, 8'hAA);
    expect_wr(6'd5, 8'h55);
    expect_wr(6'd6, 8'hC3);
    start_frame(8'h02, 24'h000004);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'hC3);
    end_frame();
    expect_rd(8'hAA);
    expect_rd(8'h55);
    expect_rd(8'hC3);
    expect_rd(8'h00);
    start_frame(8'h03, 24'h000004);
    repeat (4) send_byte(8'h00);
    end_frame();

    // Address wrap and upper-bit aliasing
    expect_wr(6'd63, 8'h11);
    expect_wr(6'd0,  8'h22);
    start_frame(8'h02, 24'h00003F);
    send_byte(8'h11);
    send_byte(8'h22);
    end_frame();
    expect_rd(8'h11);
    expect_rd(8'h22);
    start_frame(8'h03, 24'h00003F);
    repeat (2) send_byte(8'h00);
    end_frame();
    expect_rd(8'h22);
    start_frame(8'h03, 24'h123F00);
    send_byte(8'h00);
    end_frame();

    // Partial write byte is discarded
    expect_wr(6'd8, 8'h5A);
    start_frame(8'h02, 24'h000008);
    send_byte(8'h5A);
    end_frame();
    start_frame(8'h02, 24'h000008);
    repeat (5) sclk_bit(1'b1);
    end_frame();
    expect_rd(8'h5A);
    start_frame(8'h03, 24'h000008);
    send_byte(8'h00);
    end_frame();

    // Unknown command: no drive, no writes, next frame decodes normally
    oe_before = oe_cycles;
    bus_if.cs_n = 1'b0;
    tick(HALF);
    send_byte(8'h9F);
    repeat (32) sclk_bit(1'b1);
    end_frame();
    check("ignore_oe_cycles", 32'(oe_cycles - oe_before), 32'd0);
    expect_rd(8'hAA);
    start_frame(8'h03, 24'h000004);
    send_byte(8'h00);
    end_frame();

    // Reset in the middle of a read
    start_frame(8'h03, 24'h000000);
    repeat (3) sclk_bit(1'b0);
    check("mid_oe_before_rst", 32'(bus_if.miso_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_oe_after_rst", 32'(bus_if.miso_oe), 32'd0);
    check("mid_busy_after_rst", 32'(bus_if.busy), 32'd0);
    bus_if.cs_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    expect_rd(8'h00);
    expect_rd(8'h00);
    start_frame(8'h03, 24'h00003F);
    repeat (2) send_byte(8'h00);
    end_frame();
    expect_rd(8'h00);
    start_frame(8'h03, 24'h000004);
    send_byte(8'h00);
    end_frame();

    tick(20);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
